systolic_tile: RTL and testbench
================================

# systolic_tile

Parametrised output-stationary matrix-multiply tile, the next generation of the fixed 4×4 systolic array. It accepts one K-slice per beat: a column of A (ROWS elements) and a row of B (COLS elements). Operand skew is generated internally, and saturating signed accumulation is performed per PE. Results drain one row per beat over a valid/ready interface. It sits between the unified-buffer read path and the post-processing/writeback stage.

## Interface
- ROWS, 4, PE rows (≥2)
- COLS, 4, PE columns (≥2)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 32, signed accumulator width (≥2·DATA_WIDTH)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  K-slice beat valid
- in_ready  out  1  tile can accept a beat
- a_data  in  ROWS·DATA_WIDTH  A column; element i at [i·DATA_WIDTH +: DATA_WIDTH] feeds PE row i
- b_data  in  COLS·DATA_WIDTH  B row; element j feeds PE column j
- in_last  in  1  beat is the final K-slice of the tile
- acc_keep  in  1  sampled on the first beat of a tile; 1 = accumulate onto held results, 0 = overwrite
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts row
- out_data  out  COLS·ACC_WIDTH  accumulators of row out_row; column j at [j·ACC_WIDTH +: ACC_WIDTH]
- out_row  out  max(1,$clog2(ROWS))  row index of out_data
- out_last  out  1  out_row == ROWS-1 while out_valid
- sat_flag  out  1  sticky: some PE saturated during the current tile
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: the first accepted beat goes to COMPUTE, or to FLUSH if in_last is also set.
  - COMPUTE: an accepted beat with in_last goes to FLUSH.
  - FLUSH: counts ROWS+COLS-1 cycles, then goes to DRAIN.
  - DRAIN: the handshake on row ROWS-1 returns to IDLE.
- in_ready = 1 in IDLE/COMPUTE and 0 in FLUSH/DRAIN. Beat accepted = in_valid & in_ready.
- in_valid may drop between beats in COMPUTE (bubbles). Bubbles carry valid=0 through the skew and PEs, and do not modify any accumulator.
- Skew: row i operands pass through i registers and column j operands through j registers. Each carries {data, valid, clr}. PEs forward A right and B down with one register per hop.
- clr = (first beat of tile) & ~acc_keep. When a PE sees valid & clr, it loads the product; when it sees valid & ~clr, it adds the product.
- Arithmetic:
  - The product is a full 2·DATA_WIDTH-bit signed value, sign-extended to ACC_WIDTH.
  - The sum saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; saturation sets sat_flag.
  - sat_flag clears on the first beat of a tile with acc_keep=0, and is held through DRAIN.
- DRAIN:
  - out_valid=1; out_row starts at 0 and increments on each out_valid & out_ready.
  - out_data and out_row stay stable while out_ready=0.
  - Accumulators hold their values after drain. This allows acc_keep K-tiling across tiles.

## Timing
- Reset: in_ready=0 while rst is asserted and 1 after release (IDLE).
- Reset values: out_valid=0, out_data=0, out_row=0, out_last=0, sat_flag=0, busy=0. All accumulators, skew registers and valid/clr bits are 0.
- Reset mid-operation aborts the tile immediately with no output.
- Skew/MAC latency: a beat accepted at edge E updates PE[i][j] at edge E+i+j+1.
- Drain latency: in_last accepted at edge E gives out_valid=1 after edge E+ROWS+COLS-1. For the 4×4 configuration this is 7 edges.
- Drain throughput: one row per cycle with out_ready=1, so DRAIN lasts ≥ROWS cycles. in_ready rises the cycle after the last row's handshake.
- Single-beat tile: IDLE → FLUSH directly, with the same latency.
- Beats presented during FLUSH/DRAIN are not accepted (in_ready=0). The producer holds them.

## Test plan
- Identity: ROWS=COLS=4, 4 beats with a_data element i = (i==k), B row k = {4k+1..4k+4}, in_last on beat 3, acc_keep=0 -> out rows 0..3 = B rows; out_valid exactly 7 edges after in_last accept; out_last only on row 3.
- Bubbles: same stimulus with in_valid low 2 cycles between each beat -> identical out_data, and in_ready=1 throughout COMPUTE.
- Backpressure: out_ready low 5 cycles at row 0, then toggled 1/0 -> out_valid held, out_data stable while stalled, rows delivered 0,1,2,3 in order, none skipped or repeated.
- K-tiling: tile 1 all-ones A/B with K=4 -> every result 4. Tile 2 the same with acc_keep=1 -> 8. Tile 3 with acc_keep=0 -> 4.
- Saturation: ACC_WIDTH=32, a=b=-32768 for 3 beats -> 0x7FFFFFFF, sat_flag=1. With a=-32768, b=32767 for 3 beats -> 0x80000000. Next acc_keep=0 tile -> sat_flag=0.
- Reset mid-FLUSH: assert rst for 1 cycle during FLUSH -> out_valid stays 0, in_ready=1 after release. The next tile with acc_keep=1 and identity stimulus yields exactly B, because accumulators were zeroed.

Source files
------------

// File: rtl/systolic_tile.sv
// Output-stationary ROWS x COLS signed MAC tile; skewed K-slice input, PE[i][j] updates i+j+1 edges after accept.
// Results appear ROWS+COLS-1 edges after the last beat; in_ready low in FLUSH/DRAIN, rows held while out_ready=0.
module systolic_tile #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic [COLS*DATA_WIDTH-1:0] b_data,
  input  logic                      in_last,
  input  logic                      acc_keep,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*ACC_WIDTH-1:0] out_data,
  output logic [RW-1:0]             out_row,
  output logic                      out_last,
  output logic                      sat_flag,
  output logic                      busy
);
  localparam int CW = $clog2(ROWS + COLS);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] flush_cnt;
  logic          accept, first_beat;

  logic [DATA_WIDTH-1:0] a_sk [ROWS][ROWS];
  logic                  v_sk [ROWS][ROWS];
  logic                  c_sk [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] b_sk [COLS][COLS];

  logic [DATA_WIDTH-1:0] a_fw [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_fw [ROWS][COLS];
  logic                  v_fw [ROWS][COLS];
  logic                  c_fw [ROWS][COLS];

  logic [DATA_WIDTH-1:0] pe_a [ROWS][COLS];
  logic [DATA_WIDTH-1:0] pe_b [ROWS][COLS];
  logic                  pe_v [ROWS][COLS];
  logic                  pe_c [ROWS][COLS];

  logic [ACC_WIDTH-1:0] acc     [ROWS][COLS];
  logic [ACC_WIDTH-1:0] acc_nxt [ROWS][COLS];
  logic                 any_sat;

  logic [PW-1:0]        prod;
  logic [ACC_WIDTH:0]   base, sum;

  assign in_ready   = !rst && (state == S_IDLE || state == S_COMPUTE);
  assign accept     = in_valid && in_ready;
  assign first_beat = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DRAIN);
  assign out_last   = out_valid && (out_row == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = in_last ? S_FLUSH : S_COMPUTE;
      S_COMPUTE: if (accept && in_last) state_nxt = S_FLUSH;
      S_FLUSH:   if (flush_cnt == CW'(ROWS + COLS - 2)) state_nxt = S_DRAIN;
      S_DRAIN:   if (out_ready && out_row == RW'(ROWS - 1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // PE inputs: column 0 / row 0 come from the last skew stage, the rest from the neighbour's forward register.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      pe_a[i][0] = a_sk[i][i];
      pe_v[i][0] = v_sk[i][i];
      pe_c[i][0] = c_sk[i][i];
      for (int j = 1; j < COLS; j++) begin
        pe_a[i][j] = a_fw[i][j-1];
        pe_v[i][j] = v_fw[i][j-1];
        pe_c[i][j] = c_fw[i][j-1];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      pe_b[0][j] = b_sk[j][j];
      for (int i = 1; i < ROWS; i++) pe_b[i][j] = b_fw[i-1][j];
    end
  end

  // Sum carried one bit wider so overflow shows as a mismatch of the top two bits.
  always_comb begin
    any_sat = 1'b0;
    prod    = '0;
    base    = '0;
    sum     = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        prod = $signed(pe_a[i][j]) * $signed(pe_b[i][j]);
        base = pe_c[i][j] ? '0 : {acc[i][j][ACC_WIDTH-1], acc[i][j]};
        sum  = base + {{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod};
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
          acc_nxt[i][j] = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          any_sat = any_sat | pe_v[i][j];
        end else begin
          acc_nxt[i][j] = sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
      out_row   <= '0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        for (int k = 0; k < ROWS; k++) begin
          a_sk[i][k] <= '0;
          v_sk[i][k] <= 1'b0;
          c_sk[i][k] <= 1'b0;
        end
      end
      for (int j = 0; j < COLS; j++)
        for (int k = 0; k < COLS; k++) b_sk[j][k] <= '0;
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_fw[i][j] <= '0;
          b_fw[i][j] <= '0;
          v_fw[i][j] <= 1'b0;
          c_fw[i][j] <= 1'b0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
      if (out_valid && out_ready)
        out_row <= (out_row == RW'(ROWS - 1)) ? '0 : out_row + 1'b1;
      if (accept && first_beat && !acc_keep) sat_flag <= 1'b0;
      else if (any_sat)                      sat_flag <= 1'b1;

      for (int i = 0; i < ROWS; i++) begin
        a_sk[i][0] <= a_data[i*DATA_WIDTH +: DATA_WIDTH];
        v_sk[i][0] <= accept;
        c_sk[i][0] <= accept && first_beat && !acc_keep;
        for (int k = 1; k < ROWS; k++) begin
          a_sk[i][k] <= a_sk[i][k-1];
          v_sk[i][k] <= v_sk[i][k-1];
          c_sk[i][k] <= c_sk[i][k-1];
        end
      end
      for (int j = 0; j < COLS; j++) begin
        b_sk[j][0] <= b_data[j*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k < COLS; k++) b_sk[j][k] <= b_sk[j][k-1];
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_fw[i][j] <= pe_a[i][j];
          b_fw[i][j] <= pe_b[i][j];
          v_fw[i][j] <= pe_v[i][j];
          c_fw[i][j] <= pe_c[i][j];
          if (pe_v[i][j]) acc[i][j] <= acc_nxt[i][j];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++) out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[out_row][j];
  end

endmodule

// File: tb/tb_systolic_tile.sv
// Directed bench for systolic_tile (4x4, 16-bit operands, 32-bit accumulators).
module tb_systolic_tile;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [R*DW-1:0]   a_data = '0;
  logic [C*DW-1:0]   b_data = '0;
  logic              in_last = 1'b0;
  logic              acc_keep = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [C*AW-1:0]   out_data;
  logic [1:0]        out_row;
  logic              out_last;
  logic              sat_flag;
  logic              busy;

  systolic_tile #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data), .in_last(in_last), .acc_keep(acc_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int acc_cyc  = 0;
  logic [AW-1:0] exp_c [R][C];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [C*AW-1:0] exp_row(input int r);
    logic [C*AW-1:0] v;
    v = '0;
    for (int j = 0; j < C; j++) v[j*AW +: AW] = exp_c[r][j];
    return v;
  endfunction

  // kind 0: identity A / B rows {4k+1..4k+4}; 1: all ones; 2: -32768*-32768; 3: -32768*32767
  task automatic make_beat(input int kind, input int k, output logic [R*DW-1:0] a, output logic [C*DW-1:0] b);
    for (int i = 0; i < R; i++) begin
      case (kind)
        0:       a[i*DW +: DW] = (i == k) ? 16'd1 : 16'd0;
        1:       a[i*DW +: DW] = 16'd1;
        default: a[i*DW +: DW] = 16'h8000;
      endcase
    end
    for (int j = 0; j < C; j++) begin
      case (kind)
        0:       b[j*DW +: DW] = 16'(C * k + j + 1);
        1:       b[j*DW +: DW] = 16'd1;
        2:       b[j*DW +: DW] = 16'h8000;
        default: b[j*DW +: DW] = 16'h7FFF;
      endcase
    end
  endtask

  task automatic send_beat(input logic [R*DW-1:0] a, input logic [C*DW-1:0] b, input bit last, input bit keep);
    int t;
    t = 0;
    a_data = a; b_data = b; in_last = last; acc_keep = keep; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_eq("beat_accept_timeout", 128'(t), 128'(0));
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_beats(input int kind, input bit keep, input int gap, input int n);
    logic [R*DW-1:0] a;
    logic [C*DW-1:0] b;
    for (int k = 0; k < n; k++) begin
      make_beat(kind, k, a, b);
      send_beat(a, b, k == n - 1, keep);
      if (k < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          check_eq("bubble_in_ready", 128'(in_ready), 128'(1));
          @(negedge clk);
        end
      end
    end
  endtask

  // mode 1: hold out_ready low 5 cycles at row 0, then one stall cycle before each later row
  task automatic drain(input int mode, input bit exp_sat);
    int t;
    int n_stall;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_latency", 128'(cyc - acc_cyc), 128'(R + C - 1));
    for (int r = 0; r < R; r++) begin
      n_stall = (mode == 1) ? ((r == 0) ? 5 : 1) : 0;
      for (int s = 0; s < n_stall; s++) begin
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("stall_valid", 128'(out_valid), 128'(1));
        check_eq("stall_row",   128'(out_row),   128'(r));
        check_eq("stall_data",  128'(out_data),  128'(exp_row(r)));
      end
      check_eq("row_valid", 128'(out_valid), 128'(1));
      check_eq("row_index", 128'(out_row),   128'(r));
      check_eq("row_data",  128'(out_data),  128'(exp_row(r)));
      check_eq("row_last",  128'(out_last),  128'(r == R - 1));
      check_eq("sat_flag",  128'(sat_flag),  128'(exp_sat));
      out_ready = 1'b1;
      @(negedge clk);
    end
    check_eq("post_out_valid", 128'(out_valid), 128'(0));
    check_eq("post_in_ready",  128'(in_ready),  128'(1));
    check_eq("post_busy",      128'(busy),      128'(0));
  endtask

  task automatic set_exp(input int kind);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        case (kind)
          0:       exp_c[i][j] = 32'(C * i + j + 1);
          1:       exp_c[i][j] = 32'd4;
          2:       exp_c[i][j] = 32'd8;
          3:       exp_c[i][j] = 32'h7FFF_FFFF;
          default: exp_c[i][j] = 32'h8000_0000;
        endcase
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready",  128'(in_ready),  128'(0));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_data",  128'(out_data),  128'(0));
    check_eq("rst_out_row",   128'(out_row),   128'(0));
    check_eq("rst_out_last",  128'(out_last),  128'(0));
    check_eq("rst_sat_flag",  128'(sat_flag),  128'(0));
    check_eq("rst_busy",      128'(busy),      128'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 128'(in_ready), 128'(1));

    set_exp(0); run_beats(0, 1'b0, 0, 4); drain(0, 1'b0);
    set_exp(0); run_beats(0, 1'b0, 2, 4); drain(0, 1'b0);
    set_exp(0); run_beats(0, 1'b0, 0, 4); drain(1, 1'b0);

    set_exp(1); run_beats(1, 1'b0, 0, 4); drain(0, 1'b0);
    set_exp(2); run_beats(1, 1'b1, 0, 4); drain(0, 1'b0);
    set_exp(1); run_beats(1, 1'b0, 0, 4); drain(0, 1'b0);

    set_exp(3); run_beats(2, 1'b0, 0, 3); drain(0, 1'b1);
    set_exp(4); run_beats(3, 1'b0, 0, 3); drain(0, 1'b1);
    set_exp(0); run_beats(0, 1'b0, 0, 4); drain(0, 1'b0);

    // single-beat tile goes straight to FLUSH with the same latency
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) exp_c[i][j] = (i == 0) ? 32'(j + 1) : 32'd0;
    run_beats(0, 1'b0, 0, 1); drain(0, 1'b0);

    // reset during FLUSH aborts the tile and clears every accumulator
    run_beats(1, 1'b0, 0, 4);
    repeat (2) @(negedge clk);
    check_eq("flush_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready",  128'(in_ready),  128'(0));
    check_eq("midrst_busy",      128'(busy),      128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("release_in_ready", 128'(in_ready), 128'(1));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort_no_output", 128'(seen), 128'(0));
    set_exp(0); run_beats(0, 1'b1, 0, 4); drain(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
